// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame and sends start, LSB-first
// data, optional even parity and one stop bit, each held CLKS_PER_BIT cycles.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

   state_t                state;
   logic [CW-1:0]         baud;
   logic [BW-1:0]         bitcnt;
   logic [DATA_WIDTH-1:0] sr;
   logic [DATA_WIDTH-1:0] sr_nxt;
   logic                  par;
   logic                  baud_end;

   // Pop only from IDLE so each frame consumes exactly one word.
   assign fifo_rd  = rst && !fifo_empty && (state == IDLE);
   assign baud_end = (baud == CNT_LAST);
   assign sr_nxt   = sr >> 1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         baud       <= '0;
         bitcnt     <= '0;
         sr         <= '0;
         par        <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         baud       <= baud_end ? '0 : baud + 1'b1;
         case (state)
            IDLE: begin
               baud <= '0;
               if (!fifo_empty) begin
                  state <= FETCH;
                  busy  <= 1'b1;
               end
            end
            FETCH: begin
               sr     <= fifo_dout;
               par    <= ^fifo_dout;
               bitcnt <= '0;
               baud   <= '0;
               tx     <= 1'b0;
               state  <= START;
            end
            START: begin
               if (baud_end) begin
                  tx    <= sr[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (baud_end) begin
                  if (bitcnt == BIT_LAST) begin
                     if (PARITY_EN != 0) begin
                        tx    <= par;
                        state <= PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     sr     <= sr_nxt;
                     tx     <= sr_nxt[0];
                     bitcnt <= bitcnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (baud_end) begin
                  tx    <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               // Registered pulse: set one cycle early so it lands on the last stop cycle.
               if (baud == CNT_PRE) frame_done <= 1'b1;
               if (baud_end) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a default instance (A) and a parity instance (B),
// each fed by a small FIFO model; per-cycle traces are checked against hand values.
module tb_fifo_uart_tx;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rsta, emptya, rda, txa, busya, fda;
   logic       rstb, emptyb, rdb, txb, busyb, fdb;
   logic [7:0] douta, doutb;
   logic [7:0] mema [0:15];
   logic [7:0] memb [0:15];
   int         wa = 0, ra = 0, wb = 0, rb = 0;

   always_comb emptya = (wa == ra);
   always_comb emptyb = (wb == rb);
   always @(posedge clk) if (rda) begin douta <= mema[ra[3:0]]; ra <= ra + 1; end
   always @(posedge clk) if (rdb) begin doutb <= memb[rb[3:0]]; rb <= rb + 1; end

   fifo_uart_tx ua (.clk(clk), .rst(rsta), .fifo_empty(emptya), .fifo_dout(douta),
                    .fifo_rd(rda), .tx(txa), .busy(busya), .frame_done(fda));
   fifo_uart_tx #(.PARITY_EN(1)) ub (.clk(clk), .rst(rstb), .fifo_empty(emptyb),
                    .fifo_dout(doutb), .fifo_rd(rdb), .tx(txb), .busy(busyb), .frame_done(fdb));

   int   n_tests = 0, n_fail = 0;
   logic txh [0:127];
   logic rdh [0:127];
   logic bsh [0:127];
   logic fdh [0:127];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records n cycles of one instance; index 0 is the current cycle.
   task automatic rec(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         if (which == 0) begin txh[i] = txa; rdh[i] = rda; bsh[i] = busya; fdh[i] = fda; end
         else            begin txh[i] = txb; rdh[i] = rdb; bsh[i] = busyb; fdh[i] = fdb; end
         tick();
      end
   endtask

   function automatic int cnt_rd(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (rdh[i]) c++;
      return c;
   endfunction

   function automatic int cnt_fd(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (fdh[i]) c++;
      return c;
   endfunction

   function automatic logic [7:0] dec(input int base);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) d[i] = txh[base + 4 + 4*i + 2];
      return d;
   endfunction

   // Every cycle of every bit slot must hold the expected level.
   task automatic slots(input string tag, input int base, input logic [10:0] bits, input int ns);
      int bad = 0;
      for (int s = 0; s < ns; s++)
         for (int c = 0; c < 4; c++)
            if (txh[base + 4*s + c] !== bits[s]) bad++;
      chk(tag, bad, 0);
   endtask

   initial begin
      int ones, bz;
      rsta = 1'b0; rstb = 1'b0;
      mema[0] = 8'hA5; wa = 1;

      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rst_hold_rd", rda, 0);
         chk("rst_hold_tx", txa, 1);
         chk("rst_hold_busy", busya, 0);
         chk("rst_hold_fd", fda, 0);
      end

      rsta = 1'b1; rstb = 1'b1;
      rec(0, 44);
      chk("a5_rd_first", rdh[0], 1);
      chk("a5_rd_cnt", cnt_rd(44), 1);
      chk("a5_idle_tx", txh[1], 1);
      slots("a5_bits", 2, 11'b01101001010, 10);
      chk("a5_decode", dec(2), 8'hA5);
      chk("a5_fd_cnt", cnt_fd(44), 1);
      chk("a5_fd_pos", fdh[41], 1);
      chk("a5_busy0", bsh[0], 0);
      chk("a5_busy1", bsh[1], 1);
      chk("a5_busy41", bsh[41], 1);
      chk("a5_busy42", bsh[42], 0);

      mema[1] = 8'h3C; mema[2] = 8'hFF; wa = 3;
      rec(0, 90);
      chk("b2b_rd_cnt", cnt_rd(90), 2);
      chk("b2b_rd0", rdh[0], 1);
      chk("b2b_rd42", rdh[42], 1);
      slots("b2b_gap_high", 38, 11'h03F, 6 / 4);
      ones = 0;
      for (int i = 38; i < 44; i++) if (txh[i]) ones++;
      chk("b2b_gap6", ones, 6);
      chk("b2b_start2", txh[44], 0);
      slots("b2b_3c_bits", 2, 11'b01001111000, 10);
      slots("b2b_ff_bits", 44, 11'b01111111110, 10);
      chk("b2b_dec1", dec(2), 8'h3C);
      chk("b2b_dec2", dec(44), 8'hFF);
      chk("b2b_fd41", fdh[41], 1);
      chk("b2b_fd83", fdh[83], 1);
      chk("b2b_busy_idle", bsh[42], 0);

      rec(0, 100);
      ones = 0; bz = 0;
      for (int i = 0; i < 100; i++) begin
         if (txh[i]) ones++;
         if (bsh[i]) bz++;
      end
      chk("empty_rd", cnt_rd(100), 0);
      chk("empty_tx", ones, 100);
      chk("empty_busy", bz, 0);

      mema[3] = 8'h5A; mema[4] = 8'h11; wa = 5;
      rec(0, 15);
      chk("mid_rd0", rdh[0], 1);
      #1;
      chk("mid_pre_tx", txa, 0);
      rsta = 1'b0;
      #1;
      chk("mid_rst_tx", txa, 1);
      chk("mid_rst_busy", busya, 0);
      chk("mid_rst_fd", fda, 0);
      chk("mid_rst_rd", rda, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("mid_hold_rd", rda, 0);
         chk("mid_hold_tx", txa, 1);
      end
      rsta = 1'b1;
      rec(0, 44);
      chk("mid_new_rd", rdh[0], 1);
      chk("mid_new_rd_cnt", cnt_rd(44), 1);
      chk("mid_new_tx1", txh[1], 1);
      chk("mid_new_tx2", txh[2], 0);
      chk("mid_new_dec", dec(2), 8'h11);
      chk("mid_fifo_drained", ra, 5);

      memb[0] = 8'h07; memb[1] = 8'h03; wb = 2;
      rec(1, 96);
      chk("par_rd_cnt", cnt_rd(96), 2);
      chk("par_rd46", rdh[46], 1);
      slots("par_07_bits", 2, 11'b11000001110, 11);
      slots("par_03_bits", 48, 11'b10000000110, 11);
      chk("par_bit07", txh[40], 1);
      chk("par_bit03", txh[86], 0);
      chk("par_fd45", fdh[45], 1);
      chk("par_fd91", fdh[91], 1);
      chk("par_fd_cnt", cnt_fd(96), 2);
      chk("par_busy46", bsh[46], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

- Downstream consumer of the synchronous FIFO: pops one byte at a time and serializes it onto a UART-style line.
- Frame format: start bit, LSB-first data, optional even parity, one stop bit.
- Sits between the FIFO's read side (`rd`, `dout`, `empty`) and the off-chip serial pin, so the FIFO drains at line rate.

## Interface
Parameters:
- `DATA_WIDTH`, 8: FIFO word width and data bits per frame.
- `CLKS_PER_BIT`, 4: clock cycles each serial bit is held (≥2).
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_dout`  in  DATA_WIDTH: FIFO read data, valid the cycle after a pop.
- `fifo_rd`  out  1: FIFO read strobe, one-cycle pulse per byte.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is being fetched or sent.
- `frame_done`  out  1: one-cycle pulse on the last cycle of the stop bit.

## Operation
FSM states and transitions:
- `IDLE`:
  - `fifo_rd = rst && !fifo_empty` (combinational).
  - If `!fifo_empty`, go to `FETCH`; otherwise stay.
- `FETCH`: load `fifo_dout` into the shift register, compute parity, clear the bit counter → `START`.
- `START`: `tx=0` for CLKS_PER_BIT cycles → `DATA`.
- `DATA`:
  - Drive shift-register bit 0 on `tx`; shift right every CLKS_PER_BIT cycles.
  - After DATA_WIDTH bits → `PARITY` if PARITY_EN, else `STOP`.
- `PARITY`: `tx` = XOR of all data bits (even parity) for CLKS_PER_BIT cycles → `STOP`.
- `STOP`:
  - `tx=1` for CLKS_PER_BIT cycles.
  - `frame_done=1` on its final cycle.
  - → `IDLE`.

Counters and outputs:
- Baud counter: 0..CLKS_PER_BIT-1, restarted on every state change.
- Bit counter: width `$clog2(DATA_WIDTH+1)`.
- `tx`, `busy`, `frame_done` are registered. `busy = (state != IDLE)`.

Boundary conditions:
- `fifo_rd` is never asserted while `fifo_empty=1`, so the FIFO is never read when empty.
- `fifo_rd` is never asserted outside `IDLE`, so exactly one pop per frame.
- `fifo_empty` changes during a frame are ignored until the next `IDLE`.
- Reset mid-frame:
  - `tx→1`, `busy→0`, `frame_done→0`, state `IDLE` immediately (async).
  - `fifo_rd` is forced 0 while `rst=0`.
  - The popped byte is discarded and not re-sent.
- Reset values: `tx=1`, `busy=0`, `frame_done=0`, `fifo_rd=0`, shift register 0, counters 0.

## Timing
- `fifo_empty` low in IDLE cycle k:
  - `fifo_rd` high in cycle k.
  - FETCH in cycle k+1, capturing `fifo_dout`.
  - `tx` falls after edge k+2.
- Frame length: (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles of `tx` activity.
  - Defaults: 40 cycles; with parity, 44.
- Back-to-back bytes:
  - After `frame_done`, there is 1 IDLE cycle + 1 FETCH cycle of extra high line.
  - Start-to-start spacing is frame length + 2 cycles (42 at defaults).
- `busy` rises the edge after the `fifo_rd` cycle and falls the edge after `frame_done`.

## Test plan
- Reset hold: `rst=0` with `fifo_empty=0` → `fifo_rd=0`, `tx=1`, `busy=0`, `frame_done=0` throughout.
- Single byte 0xA5, defaults:
  - Exactly one `fifo_rd` pulse.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `frame_done` pulses on cycle 40 of the frame.
- Back-to-back 0x3C then 0xFF:
  - Two `fifo_rd` pulses, 42 cycles apart.
  - Line high for 6 cycles between the frames.
  - Data decodes as 0x3C, 0xFF.
- `PARITY_EN=1`:
  - 0x07 → parity bit 1; 0x03 → parity bit 0.
  - Frame is 44 cycles.
- FIFO empty: `fifo_empty` held 1 for 100 cycles → no `fifo_rd`, `tx=1`, `busy=0`.
- Reset mid-DATA:
  - Assert `rst=0` during bit 3 of 0x5A → `tx=1` at once.
  - On release with FIFO non-empty, a new full frame starts 2 cycles later with the next byte.
